// File: rtl/ic_gb8_stripe_scheduler.sv
// Ping-pong stripe buffer scheduler feeding the 8x8 block extractor.
// Owns the bank states, the write address and back-pressure, the block
// read grants and the frame-level stripe and block counters.
module ic_gb8_stripe_scheduler #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  IC_X_image,
  input  logic [DIM_W-1:0]  IC_Y_image,
  input  logic              GB8_inputready,
  input  logic              blk_done,
  output logic              in_ready,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_address,
  output logic              rd_bank,
  output logic              block_valid,
  output logic [ADDR_W-1:0] block_col,
  output logic [DIM_W-4:0]  stripe_row,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_error,
  output logic              overflow
);
  localparam int unsigned SW = DIM_W - 3;
  localparam int unsigned PW = ADDR_W + 3;
  localparam logic [PW-1:0] WPS_MAX = PW'((2 ** ADDR_W) - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} fsm_t;
  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILL = 2'd1, B_FULL = 2'd2, B_DRAIN = 2'd3} bank_t;

  fsm_t              state_q;
  fsm_t              state_d;
  logic [1:0][1:0]   bank_q;
  logic [ADDR_W-1:0] wps_q;
  logic [ADDR_W-1:0] bps_q;
  logic [SW-1:0]     ns_q;
  logic [SW-1:0]     wr_stripes_q;

  logic [PW-1:0]     x_ext;
  logic [PW-1:0]     x6;
  logic              cfg_bad;
  logic              start_ok;
  logic              accept;

  // Dimension legality: multiples of 8, non-zero, stripe fits the buffer
  always_comb begin
    x_ext    = PW'(IC_X_image);
    x6       = (x_ext << 2) + (x_ext << 1);
    cfg_bad  = (IC_X_image == '0) || (IC_Y_image == '0) ||
               (IC_X_image[2:0] != 3'd0) || (IC_Y_image[2:0] != 3'd0) ||
               (x6 > WPS_MAX);
    start_ok = (state_q == S_IDLE) && start && !cfg_bad;
    accept   = GB8_inputready && in_ready;
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Frame next-state: run until every stripe has been released
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (stripe_row == ns_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame-state decodes and write back-pressure
  always_comb begin
    busy       = (state_q == S_RUN);
    frame_done = (state_q == S_DONE);
    in_ready   = (state_q == S_RUN) &&
                 ((bank_q[wr_bank] == B_EMPTY) || (bank_q[wr_bank] == B_FILL)) &&
                 (wr_stripes_q < ns_q);
  end

  // Bank sequencing, counters and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q       <= '0;
      wps_q        <= '0;
      bps_q        <= '0;
      ns_q         <= '0;
      wr_stripes_q <= '0;
      wr_bank      <= 1'b0;
      wr_address   <= '0;
      rd_bank      <= 1'b0;
      block_valid  <= 1'b0;
      block_col    <= '0;
      stripe_row   <= '0;
      cfg_error    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      cfg_error <= (state_q == S_IDLE) && start && cfg_bad;
      if (GB8_inputready && !in_ready) overflow <= 1'b1;
      if (start_ok) begin
        wps_q    <= ADDR_W'(x6);
        bps_q    <= ADDR_W'(IC_X_image >> 3);
        ns_q     <= SW'(IC_Y_image >> 3);
        overflow <= 1'b0;
      end
      if (state_q == S_DONE) begin
        bank_q       <= '0;
        wr_stripes_q <= '0;
        wr_bank      <= 1'b0;
        wr_address   <= '0;
        rd_bank      <= 1'b0;
        block_valid  <= 1'b0;
        block_col    <= '0;
        stripe_row   <= '0;
      end else begin
        // Writer: fill wr_bank, hand it over once a full stripe is in
        if (accept) begin
          if (wr_address == wps_q - ADDR_W'(1)) begin
            bank_q[wr_bank] <= B_FULL;
            wr_address      <= '0;
            wr_bank         <= ~wr_bank;
            wr_stripes_q    <= wr_stripes_q + SW'(1);
          end else begin
            bank_q[wr_bank] <= B_FILL;
            wr_address      <= wr_address + ADDR_W'(1);
          end
        end
        // Reader: claim a full bank, then step through its blocks
        if (!block_valid && (bank_q[rd_bank] == B_FULL)) begin
          bank_q[rd_bank] <= B_DRAIN;
          block_valid     <= 1'b1;
          block_col       <= '0;
        end else if (blk_done && block_valid) begin
          if (block_col == bps_q - ADDR_W'(1)) begin
            bank_q[rd_bank] <= B_EMPTY;
            block_valid     <= 1'b0;
            rd_bank         <= ~rd_bank;
            stripe_row      <= stripe_row + SW'(1);
          end else begin
            block_col <= block_col + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ic_gb8_stripe_scheduler.sv
// Self-checking bench for the stripe scheduler: directed corner cases plus
// a scoreboarded full frame.
module tb_ic_gb8_stripe_scheduler;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DIM_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [DIM_W-1:0]  IC_X_image;
  logic [DIM_W-1:0]  IC_Y_image;
  logic              GB8_inputready;
  logic              blk_done;
  logic              in_ready;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_address;
  logic              rd_bank;
  logic              block_valid;
  logic [ADDR_W-1:0] block_col;
  logic [DIM_W-4:0]  stripe_row;
  logic              busy;
  logic              frame_done;
  logic              cfg_error;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  ic_gb8_stripe_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .IC_X_image(IC_X_image), .IC_Y_image(IC_Y_image),
    .GB8_inputready(GB8_inputready), .blk_done(blk_done),
    .in_ready(in_ready), .wr_bank(wr_bank), .wr_address(wr_address),
    .rd_bank(rd_bank), .block_valid(block_valid), .block_col(block_col),
    .stripe_row(stripe_row), .busy(busy), .frame_done(frame_done),
    .cfg_error(cfg_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int x, input int y);
    start      = 1'b1;
    IC_X_image = DIM_W'(x);
    IC_Y_image = DIM_W'(y);
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Drives a whole frame with a ready-respecting producer; block ids are
  // pushed when a stripe's last word is accepted and popped on each grant.
  task automatic run_frame(input int x, input int y, input int period);
    int wps = 6 * x;
    int bps = x / 8;
    int ns  = y / 8;
    int total = wps * ns;
    int sent = 0;
    int blocks = 0;
    int fdone = 0;
    int n = 0;
    int first_full = -10;
    bit ir_checked = 1'b0;
    logic [31:0] exp;
    do_start(x, y);
    check("run_busy", 32'(busy), 32'd1);
    while (fdone == 0 && n < 5000) begin
      if (frame_done) fdone++;
      if (n == first_full + 1) check("valid_latency0", 32'(block_valid), 32'd0);
      if (n == first_full + 2) begin
        check("valid_latency1", 32'(block_valid), 32'd1);
        check("first_col", 32'(block_col), 32'd0);
      end
      GB8_inputready = (sent < total) && in_ready;
      if (GB8_inputready) begin
        check("wr_addr", 32'(wr_address), 32'(sent % wps));
        check("wr_bank", 32'(wr_bank), 32'((sent / wps) % 2));
        if (sent % wps == wps - 1) begin
          for (int c = 0; c < bps; c++) sb.push_back({16'(sent / wps), 16'(c)});
          if (sent == wps - 1) first_full = n;
        end
        sent++;
      end else if (sent >= total && busy && !ir_checked) begin
        check("in_ready_after_last", 32'(in_ready), 32'd0);
        ir_checked = 1'b1;
      end
      blk_done = block_valid && (n % period == 0);
      if (blk_done) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          exp = sb.pop_front();
          check("block_id", {16'(stripe_row), 16'(block_col)}, exp);
        end
        blocks++;
      end
      tick();
      n++;
    end
    GB8_inputready = 1'b0;
    blk_done       = 1'b0;
    check("frame_timeout", 32'(n < 5000), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (frame_done) fdone++;
    end
    check("frame_done_once", 32'(fdone), 32'd1);
    check("blocks_total", 32'(blocks), 32'(bps * ns));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("words_total", 32'(sent), 32'(total));
    check("no_overflow", 32'(overflow), 32'd0);
    check("idle_row", 32'(stripe_row), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bad_x[6] = '{12, 1366, 0, 16, 16, 1368};
    int bad_y[6] = '{16, 16, 16, 0, 12, 8};
    int acc;
    reset_n = 1'b0;
    start = 1'b0;
    IC_X_image = '0;
    IC_Y_image = '0;
    GB8_inputready = 1'b0;
    blk_done = 1'b0;
    repeat (2) tick();
    check("reset_flags", 32'({in_ready, wr_bank, rd_bank, block_valid, busy, frame_done, cfg_error, overflow}), 32'd0);
    check("reset_addr", 32'(wr_address), 32'd0);
    check("reset_pos", {16'(stripe_row), 16'(block_col)}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Illegal dimensions
    for (int i = 0; i < 6; i++) begin
      do_start(bad_x[i], bad_y[i]);
      check("cfg_error_pulse", 32'(cfg_error), 32'd1);
      check("cfg_busy", 32'(busy), 32'd0);
      tick();
      check("cfg_error_clear", 32'(cfg_error), 32'd0);
    end
    // Largest legal width
    do_start(1360, 8);
    check("max_x_no_err", 32'(cfg_error), 32'd0);
    check("max_x_busy", 32'(busy), 32'd1);
    pulse_reset();

    // Asynchronous reset mid-frame
    do_start(16, 16);
    GB8_inputready = 1'b1;
    repeat (50) tick();
    GB8_inputready = 1'b0;
    check("mid_addr", 32'(wr_address), 32'd50);
    #2 reset_n = 1'b0;
    #1;
    check("async_flags", 32'({in_ready, wr_bank, rd_bank, block_valid, busy, frame_done, cfg_error, overflow}), 32'd0);
    check("async_addr", 32'(wr_address), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Full 16x16 frame
    run_frame(16, 16, 4);
    run_frame(24, 16, 1);

    // Back-pressure, spurious inputs, overflow
    do_start(8, 24);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("spurious_blk", {16'(stripe_row), 15'(block_col), block_valid}, 32'd0);
    start = 1'b1;
    IC_X_image = 16'd16;
    IC_Y_image = 16'd16;
    tick();
    start = 1'b0;
    check("start_busy_ignored", 32'({cfg_error, busy}), 32'd1);
    acc = 0;
    GB8_inputready = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (in_ready) acc++;
      tick();
    end
    GB8_inputready = 1'b0;
    check("bp_accepted", 32'(acc), 32'd96);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_wr", {16'(wr_bank), 16'(wr_address)}, 32'd0);
    check("bp_valid", 32'({block_valid, rd_bank}), 32'h2);
    GB8_inputready = 1'b1;
    tick();
    GB8_inputready = 1'b0;
    check("overflow_set", 32'(overflow), 32'd1);
    check("overflow_addr", 32'(wr_address), 32'd0);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("release_ready", 32'({in_ready, wr_bank}), 32'h2);
    check("release_addr", 32'(wr_address), 32'd0);
    check("release_rd", 32'({block_valid, rd_bank}), 32'h1);
    check("release_row", 32'(stripe_row), 32'd1);
    check("overflow_sticky", 32'(overflow), 32'd1);
    tick();
    check("bank1_grant", 32'({block_valid, rd_bank}), 32'h3);
    check("bank1_col", 32'(block_col), 32'd0);
    pulse_reset();

    // Simultaneous writer completion and reader release
    do_start(8, 24);
    GB8_inputready = 1'b1;
    repeat (95) tick();
    check("sim_pre_wr", {16'(wr_bank), 16'(wr_address)}, {16'd1, 16'd47});
    check("sim_pre_rd", 32'({block_valid, rd_bank}), 32'h2);
    blk_done = 1'b1;
    tick();
    GB8_inputready = 1'b0;
    blk_done = 1'b0;
    check("sim_rd", 32'({block_valid, rd_bank}), 32'h1);
    check("sim_row", 32'(stripe_row), 32'd1);
    check("sim_wr", {15'(wr_address), in_ready, 15'd0, wr_bank}, {15'd0, 1'b1, 15'd0, 1'b0});
    tick();
    check("sim_grant", 32'({block_valid, rd_bank}), 32'h3);
    check("sim_col", 32'(block_col), 32'd0);
    GB8_inputready = 1'b1;
    repeat (48) tick();
    GB8_inputready = 1'b0;
    check("last_stripe_ready", 32'(in_ready), 32'd0);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    tick();
    check("third_grant", {16'(stripe_row), 14'd0, block_valid, rd_bank}, {16'd2, 16'h2});
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("end_row", 32'({frame_done, busy}), 32'h1);
    tick();
    check("end_pulse", 32'({frame_done, busy}), 32'h2);
    tick();
    check("end_clear", {16'(stripe_row), 15'd0, frame_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_gb8_stripe_scheduler.md
Name: ic_gb8_stripe_scheduler

Overview:
- Sequences the two 8-row ping-pong stripe buffers feeding the 8x8 block extractor in the JPEG compression path.
- Owns the bank state (empty/filling/full/draining) and produces write addresses and input back-pressure.
- Issues block-by-block read grants to the downstream DCT stage.
- Tracks stripe and block counts across a whole image and signals frame completion.

Parameters:
ADDR_W, 13, buffer word-address width; words per stripe = 6*X must fit.
DIM_W, 16, width of image dimension inputs.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch dimensions and begin a frame
IC_X_image  in  DIM_W  image width in pixels
IC_Y_image  in  DIM_W  image height in pixels
GB8_inputready  in  1  one 32-bit input word is presented this cycle
blk_done  in  1  downstream has consumed the current 8x8 block
in_ready  out  1  scheduler can accept an input word
wr_bank  out  1  bank selected for writing
wr_address  out  ADDR_W  word address within wr_bank
rd_bank  out  1  bank being drained
block_valid  out  1  a block in rd_bank is available
block_col  out  ADDR_W  block column index within the stripe
stripe_row  out  DIM_W-3  index of the stripe currently being drained
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
cfg_error  out  1  one-cycle pulse when start carries illegal dimensions
overflow  out  1  sticky; word presented while in_ready=0

Behaviour:
- Reset: all outputs, counters and bank states are 0. Both banks are EMPTY. FSM is IDLE. Reset takes effect immediately at any point, including mid-frame.
- Top-level FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch X and Y.
  - Illegal if X==0, Y==0, X[2:0]!=0, Y[2:0]!=0, or 6*X > 2^ADDR_W-1. Illegal start pulses cfg_error for 1 cycle and stays IDLE.
  - Legal start: go to RUN. busy=1 from the next cycle.
  - Derived values: WPS=6*X words per stripe; BPS=X>>3 blocks per stripe; NS=Y>>3 stripes per frame.
- start while not IDLE: ignored.
- Per-bank state, 2 bits: EMPTY=0, FILL=1, FULL=2, DRAIN=3.
- Write side:
  - in_ready = RUN && state[wr_bank] in {EMPTY, FILL} && stripes_written < NS. It is combinational from registered state.
  - Accept = GB8_inputready && in_ready. wr_address equals the fill count during the accepting cycle.
  - On accept: the bank goes to FILL and the count increments.
  - On accept with count == WPS-1: the bank goes to FULL, count resets to 0, wr_bank toggles and stripes_written increments.
  - GB8_inputready && !in_ready sets overflow, which is cleared only by reset or a legal start. The word is dropped.
- Read side:
  - When block_valid=0 and state[rd_bank]==FULL: the bank goes to DRAIN. block_valid=1 and block_col=0 on the next edge, i.e. 1-cycle latency from FULL.
  - blk_done && block_valid with block_col < BPS-1: block_col increments; block_valid stays 1.
  - blk_done && block_valid with block_col == BPS-1: the bank goes to EMPTY, block_valid=0, rd_bank toggles and stripe_row increments.
  - blk_done with block_valid=0: ignored.
- Simultaneous events:
  - The writer completing one bank and the reader releasing the other bank in the same cycle are both applied.
  - A released bank is writable from the following cycle.
  - The writer never enters a FULL or DRAIN bank, so in_ready stays low until release.
- Frame end:
  - When the last stripe is released (stripe_row reaches NS), go to DONE.
  - DONE pulses frame_done for 1 cycle, clears busy and all counters, and returns to IDLE.
- Widths: all count compares are unsigned. 6*X is computed as (X<<2)+(X<<1) in ADDR_W+3 bits before the range check.

Test Plan:
- Reset values: reset asserted mid-frame (after 50 words) -> all outputs 0 asynchronously, both banks EMPTY, and a new start works normally.
- Config rejection: start with X=12, Y=16 -> cfg_error pulse, busy stays 0. Start with X=1366 -> cfg_error. Start with X=0 -> cfg_error.
- Full 16x16 frame, continuous input, blk_done every 4 cycles:
  - WPS=96, BPS=2, NS=2.
  - Bank0 FULL after word 95, block_valid 1 cycle later.
  - Second stripe fills bank1 in parallel with draining bank0.
  - 4 blocks total, frame_done exactly once, in_ready low after word 191.
- Back-pressure with X=8, Y=24, blk_done withheld:
  - Both banks FULL after 96 words; in_ready=0.
  - An extra word sets overflow.
  - Releasing bank0 raises in_ready the next cycle with wr_bank=0 and wr_address=0.
- Simultaneous completion: last write to bank1 and last blk_done on bank0 in the same cycle -> bank1 FULL, bank0 EMPTY, rd_bank=1, block_valid=1 the following cycle.
- Spurious inputs: blk_done with block_valid=0, and start while busy -> no state change.
